// File: rtl/i2s_master_tx.sv
// i2s_master_tx: clock-master I2S transmitter.
// Generates BCLK/LRCLK from clk and serializes packed stereo samples as
// standard I2S (MSB one BCLK after each LRCLK edge).
// Build option: I2S_TX_HOLD_ON_UNDERRUN_EN -- when defined, an underrun frame
// repeats the last loaded frame; otherwise an underrun frame is silence.
// Ports:
//   clk, reset_n       system clock, async active-low reset
//   tx_en              run enable; low forces the serial outputs idle
//   sample_data/valid  packed {left, right} sample offer
//   sample_ready       holding register empty
//   i2s_bclk/lrclk     serial clocks (lrclk: 0 = left, 1 = right)
//   i2s_sdata          serial data, changes on BCLK falling edges
//   frame_start        one-clk pulse per frame load
//   underrun           one-clk pulse when a frame loads with no sample held
module i2s_master_tx #(
    parameter int unsigned SAMPLE_BITS = 16,
    parameter int unsigned SLOT_BITS   = 32,
    parameter int unsigned BCLK_DIV    = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     tx_en,
    input  logic [2*SAMPLE_BITS-1:0] sample_data,
    input  logic                     sample_valid,
    output logic                     sample_ready,
    output logic                     i2s_bclk,
    output logic                     i2s_lrclk,
    output logic                     i2s_sdata,
    output logic                     frame_start,
    output logic                     underrun
);

    localparam int unsigned FRAME_W = 2 * SAMPLE_BITS;
    localparam int unsigned DIV_W   = $clog2(BCLK_DIV);
    localparam int unsigned BIT_W   = $clog2(2 * SLOT_BITS);
    localparam int unsigned IDX_W   = (SAMPLE_BITS > 1) ? $clog2(SAMPLE_BITS) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);
    localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_BITS);

    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               bclk_q, bclk_d;
    logic               lrclk_q, lrclk_d;
    logic               sdata_q, sdata_d;
    logic               frame_start_q, frame_start_d;
    logic               underrun_q, underrun_d;
    logic               hold_full_q, hold_full_d;
    logic [FRAME_W-1:0] hold_data_q, hold_data_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
`ifdef I2S_TX_HOLD_ON_UNDERRUN_EN
    logic [FRAME_W-1:0] last_frame_q, last_frame_d;
`endif

    logic                   accept;
    logic                   fall;
    logic                   load;
    logic [BIT_W-1:0]       next_bit;
    logic [BIT_W-1:0]       slot_bit;
    logic [IDX_W-1:0]       sample_idx;
    logic [SAMPLE_BITS-1:0] ch_word;

    // Divider, bit counter, serializer and holding register next state
    always_comb begin
        div_cnt_d     = div_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        bclk_d        = bclk_q;
        lrclk_d       = lrclk_q;
        sdata_d       = sdata_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;
        hold_full_d   = hold_full_q;
        hold_data_d   = hold_data_q;
        frame_d       = frame_q;
`ifdef I2S_TX_HOLD_ON_UNDERRUN_EN
        last_frame_d  = last_frame_q;
`endif
        accept     = sample_valid & ~hold_full_q;
        fall       = 1'b0;
        load       = 1'b0;
        next_bit   = bit_cnt_q;
        slot_bit   = '0;
        sample_idx = '0;
        ch_word    = '0;

        if (!tx_en) begin
            // Idle: park the counters so re-enable starts a fresh frame
            div_cnt_d = '0;
            bit_cnt_d = BIT_LAST;
            bclk_d    = 1'b0;
            lrclk_d   = 1'b0;
            sdata_d   = 1'b0;
        end else if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            bclk_d    = ~bclk_q;
            fall      = bclk_q;
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        if (fall) begin
            if (bit_cnt_q == BIT_LAST) begin
                next_bit = '0;
                load     = 1'b1;
            end else begin
                next_bit = bit_cnt_q + BIT_W'(1);
            end
            bit_cnt_d = next_bit;
            lrclk_d   = (next_bit >= SLOT_LEN);
            slot_bit  = lrclk_d ? (next_bit - SLOT_LEN) : next_bit;
            ch_word   = lrclk_d ? frame_q[SAMPLE_BITS-1:0] : frame_q[FRAME_W-1:SAMPLE_BITS];
            // Slot bit b carries channel bit [SAMPLE_BITS-b]
            sample_idx = IDX_W'(SAMPLE_BITS - 1) - IDX_W'(slot_bit - BIT_W'(1));
            if ((slot_bit >= BIT_W'(1)) && (slot_bit <= BIT_W'(SAMPLE_BITS))) begin
                sdata_d = ch_word[sample_idx];
            end else begin
                sdata_d = 1'b0;
            end
        end

        // Load sees the pre-edge holding state; a same-clk accept waits a frame
        if (load) begin
            frame_start_d = 1'b1;
            if (hold_full_q) begin
                frame_d     = hold_data_q;
                hold_full_d = 1'b0;
`ifdef I2S_TX_HOLD_ON_UNDERRUN_EN
                last_frame_d = hold_data_q;
`endif
            end else begin
                underrun_d = 1'b1;
`ifdef I2S_TX_HOLD_ON_UNDERRUN_EN
                frame_d = last_frame_q;
`else
                frame_d = '0;
`endif
            end
        end

        if (accept) begin
            hold_full_d = 1'b1;
            hold_data_d = sample_data;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q     <= '0;
            bit_cnt_q     <= BIT_LAST;
            bclk_q        <= 1'b0;
            lrclk_q       <= 1'b0;
            sdata_q       <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            hold_full_q   <= 1'b0;
            hold_data_q   <= '0;
            frame_q       <= '0;
`ifdef I2S_TX_HOLD_ON_UNDERRUN_EN
            last_frame_q  <= '0;
`endif
        end else begin
            div_cnt_q     <= div_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            bclk_q        <= bclk_d;
            lrclk_q       <= lrclk_d;
            sdata_q       <= sdata_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            hold_full_q   <= hold_full_d;
            hold_data_q   <= hold_data_d;
            frame_q       <= frame_d;
`ifdef I2S_TX_HOLD_ON_UNDERRUN_EN
            last_frame_q  <= last_frame_d;
`endif
        end
    end

    assign sample_ready = ~hold_full_q;
    assign i2s_bclk     = bclk_q;
    assign i2s_lrclk    = lrclk_q;
    assign i2s_sdata    = sdata_q;
    assign frame_start  = frame_start_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_master_tx.sv
// Bench for i2s_master_tx: time-based reference model plus directed checks.
module tb_i2s_master_tx;

    localparam int SB   = 16;
    localparam int SLOT = 32;
    localparam int DIV  = 4;
    localparam int BCLK = 2 * DIV;
    localparam int FCLK = 2 * SLOT * BCLK;

    logic          clk;
    logic          reset_n;
    logic          tx_en;
    logic [2*SB-1:0] sample_data;
    logic          sample_valid;
    logic          sample_ready;
    logic          i2s_bclk;
    logic          i2s_lrclk;
    logic          i2s_sdata;
    logic          frame_start;
    logic          underrun;

    int errors = 0;
    int checks = 0;
    int kd = 0;
    int fs_cnt = 0;
    int ur_cnt = 0;

    i2s_master_tx #(.SAMPLE_BITS(SB), .SLOT_BITS(SLOT), .BCLK_DIV(DIV)) dut (
        .clk(clk), .reset_n(reset_n), .tx_en(tx_en),
        .sample_data(sample_data), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk),
        .i2s_sdata(i2s_sdata), .frame_start(frame_start), .underrun(underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: outputs as a function of clk edges since enable
    int          k_m = 0;
    logic        m_full = 1'b0;
    logic [31:0] m_hold = '0;
    logic [31:0] m_frame = '0;
    logic [31:0] m_last = '0;
    logic        e_bclk = 1'b0, e_lr = 1'b0, e_sd = 1'b0, e_fs = 1'b0, e_ur = 1'b0;
    logic        acc;

    always begin
        @(posedge clk);
        if (!reset_n) begin
            k_m = 0; m_full = 1'b0; m_hold = '0; m_frame = '0; m_last = '0;
            e_bclk = 1'b0; e_lr = 1'b0; e_sd = 1'b0; e_fs = 1'b0; e_ur = 1'b0;
        end else begin
            acc  = sample_valid && !m_full;
            e_fs = 1'b0;
            e_ur = 1'b0;
            if (!tx_en) begin
                k_m = 0; e_bclk = 1'b0; e_lr = 1'b0; e_sd = 1'b0;
            end else begin
                k_m++;
                e_bclk = ((k_m / DIV) % 2) == 1;
                if (k_m % FCLK == BCLK) begin
                    e_fs = 1'b1;
                    if (m_full) begin
                        m_frame = m_hold; m_last = m_hold; m_full = 1'b0;
                    end else begin
                        e_ur = 1'b1;
`ifdef I2S_TX_HOLD_ON_UNDERRUN_EN
                        m_frame = m_last;
`else
                        m_frame = '0;
`endif
                    end
                end
                if (k_m >= BCLK) begin
                    int n, pos, b;
                    n   = k_m / BCLK - 1;
                    pos = n % (2 * SLOT);
                    e_lr = pos >= SLOT;
                    b   = pos % SLOT;
                    if (b >= 1 && b <= SB) e_sd = m_frame[e_lr ? (SB - b) : (2 * SB - b)];
                    else e_sd = 1'b0;
                end
            end
            if (acc) begin
                m_full = 1'b1; m_hold = sample_data;
            end
        end
        #1;
        check("m_bclk",  32'(i2s_bclk),     32'(e_bclk));
        check("m_lrclk", 32'(i2s_lrclk),    32'(e_lr));
        check("m_sdata", 32'(i2s_sdata),    32'(e_sd));
        check("m_fs",    32'(frame_start),  32'(e_fs));
        check("m_ur",    32'(underrun),     32'(e_ur));
        check("m_ready", 32'(sample_ready), 32'(!m_full));
        if (frame_start) fs_cnt++;
        if (underrun) ur_cnt++;
    end

    task automatic tick();
        @(negedge clk);
        kd++;
    endtask

    task automatic go_k(input int j);
        while (kd < j) tick();
    endtask

    task automatic check_idle(input string name);
        check({name, "_bclk"},  32'(i2s_bclk), 0);
        check({name, "_lrclk"}, 32'(i2s_lrclk), 0);
        check({name, "_sdata"}, 32'(i2s_sdata), 0);
        check({name, "_fs"},    32'(frame_start), 0);
        check({name, "_ur"},    32'(underrun), 0);
        check({name, "_ready"}, 32'(sample_ready), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        tx_en = 1'b0; sample_valid = 1'b0; reset_n = 1'b0;
        #1;
        check_idle("rst");
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic enable();
        tick();
        tx_en = 1'b1;
        kd = 0; fs_cnt = 0; ur_cnt = 0;
    endtask

    // Present a word at the current negedge for one clk
    task automatic push(input logic [31:0] w);
        sample_valid = 1'b1; sample_data = w;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic wait_ready();
        for (int t = 0; t < 2000 && !sample_ready; t++) tick();
        check("ready_timeout", 32'(sample_ready), 1);
    endtask

    initial begin
        reset_n = 1'b1; tx_en = 1'b0; sample_valid = 1'b0; sample_data = '0;
        #2 reset_n = 1'b0;
        #20 reset_n = 1'b1;

        // No stimulus: clocks start, silence, underrun every frame
        do_reset();
        enable();
        go_k(3);   check("s1_bclk3", 32'(i2s_bclk), 0);
        go_k(4);   check("s1_bclk4", 32'(i2s_bclk), 1);
        go_k(8);   check("s1_bclk8", 32'(i2s_bclk), 0);
                   check("s1_fs8", 32'(frame_start), 1);
                   check("s1_ur8", 32'(underrun), 1);
        go_k(263); check("s1_lr263", 32'(i2s_lrclk), 0);
        go_k(264); check("s1_lr264", 32'(i2s_lrclk), 1);
        go_k(520); check("s1_ur520", 32'(underrun), 1);
                   check("s1_lr520", 32'(i2s_lrclk), 0);

        // Pre-loaded word 0xA5C3_0F0F
        do_reset();
        push(32'hA5C3_0F0F);
        check("s2_ready", 32'(sample_ready), 0);
        enable();
        go_k(8);   check("s2_fs", 32'(frame_start), 1);
                   check("s2_ur", 32'(underrun), 0);
        go_k(16);  check("s2_l1", 32'(i2s_sdata), 1);
        go_k(24);  check("s2_l2", 32'(i2s_sdata), 0);
        go_k(32);  check("s2_l3", 32'(i2s_sdata), 1);
        go_k(144); check("s2_l17", 32'(i2s_sdata), 0);
        go_k(272); check("s2_r1", 32'(i2s_sdata), 0);
        go_k(304); check("s2_r5", 32'(i2s_sdata), 1);
        go_k(520); check("s2_ur520", 32'(underrun), 1);
                   check("s2_fscnt", 32'(fs_cnt), 2);

        // Stream four words, each offered when ready
        do_reset();
        enable();
        begin
            logic [31:0] words [4];
            words[0] = 32'h1234_ABCD; words[1] = 32'hFFFF_0000;
            words[2] = 32'h0001_8000; words[3] = 32'h5A5A_C3C3;
            for (int i = 0; i < 4; i++) begin
                wait_ready();
                push(words[i]);
            end
        end
        go_k(1600);
        check("s3_fscnt", 32'(fs_cnt), 4);
        check("s3_urcnt", 32'(ur_cnt), 0);

        // One word then starvation
        do_reset();
        push(32'h8001_7FFE);
        enable();
        go_k(16);  check("s4_l1", 32'(i2s_sdata), 1);
        go_k(520); check("s4_ur", 32'(underrun), 1);
                   check("s4_fs", 32'(frame_start), 1);
`ifdef I2S_TX_HOLD_ON_UNDERRUN_EN
        go_k(528); check("s4_f2_l1", 32'(i2s_sdata), 1);
        go_k(792); check("s4_f2_r2", 32'(i2s_sdata), 1);
`else
        go_k(528); check("s4_f2_l1", 32'(i2s_sdata), 0);
        go_k(792); check("s4_f2_r2", 32'(i2s_sdata), 0);
`endif

        // Offer exactly in the load-edge clk with the register empty
        do_reset();
        enable();
        go_k(519);
        push(32'hC000_0001);
        check("s5_ur520", 32'(underrun), 1);
        check("s5_ready", 32'(sample_ready), 0);
        go_k(528);  check("s5_f2_l1", 32'(i2s_sdata), 0);
        go_k(1032); check("s5_ur1032", 32'(underrun), 0);
                    check("s5_fs1032", 32'(frame_start), 1);
        go_k(1040); check("s5_f3_l1", 32'(i2s_sdata), 1);

        // Drop tx_en mid-frame, re-enable, then async reset mid-frame
        do_reset();
        push(32'h1234_5678);
        enable();
        go_k(8);
        push(32'hF00D_BEEF);
        go_k(172); check("s6_bclk172", 32'(i2s_bclk), 1);
        tx_en = 1'b0;
        tick();
        check("s6_off_bclk", 32'(i2s_bclk), 0);
        check("s6_off_lr", 32'(i2s_lrclk), 0);
        check("s6_off_sd", 32'(i2s_sdata), 0);
        check("s6_off_ready", 32'(sample_ready), 0);
        go_k(193);
        enable();
        go_k(7);   check("s6_fs7", 32'(frame_start), 0);
        go_k(8);   check("s6_fs8", 32'(frame_start), 1);
                   check("s6_ur8", 32'(underrun), 0);
        go_k(16);  check("s6_l1", 32'(i2s_sdata), 1);
        push(32'hFFFF_FFFF);
        go_k(333); check("s6_pre_bclk", 32'(i2s_bclk), 1);
                   check("s6_pre_lr", 32'(i2s_lrclk), 1);
                   check("s6_pre_ready", 32'(sample_ready), 0);
        reset_n = 1'b0;
        #1;
        check_idle("s6_arst");
        @(negedge clk);
        reset_n = 1'b1;
        tx_en = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2s_master_tx.md
# i2s_master_tx

Clock-master I2S transmitter for the audio path. It drives BCLK and LRCLK from the system clock and serializes packed stereo samples onto SDATA. The transmitted stream is standard I2S, with the MSB one BCLK after each LRCLK edge. It is the counterpart of the slave-mode receive path: it lets the FPGA source the serial clocks to a codec or to a loopback slave, instead of taking them from the codec.

## Interface
Parameters:
- SAMPLE_BITS, 16, bits per channel; left and right are packed into the sample word.
- SLOT_BITS, 32, BCLK periods per channel slot; must be ≥ SAMPLE_BITS+1.
- BCLK_DIV, 4, clk cycles per BCLK half-period; must be ≥ 2.

Ports:
- clk  in  1  system clock; the block has one clock; all logic runs on its rising edge.
- reset_n  in  1  reset, asynchronous assert, active-low.
- tx_en  in  1  run enable; when low, the serial outputs idle.
- sample_data  in  2*SAMPLE_BITS  {left[SAMPLE_BITS-1:0], right[SAMPLE_BITS-1:0]}.
- sample_valid  in  1  sample_data is offered this cycle.
- sample_ready  out  1  holding register is empty; a sample is accepted when valid && ready.
- i2s_bclk  out  1  bit clock.
- i2s_lrclk  out  1  word select: 0 = left slot, 1 = right slot.
- i2s_sdata  out  1  serial data; changes only on BCLK falling edges.
- frame_start  out  1  one-clk pulse when a new frame is loaded.
- underrun  out  1  one-clk pulse when a frame is loaded with no sample pending.

## Operation
- Reset values:
  - i2s_bclk=0, i2s_lrclk=0, i2s_sdata=0.
  - frame_start=0, underrun=0.
  - holding register empty, so sample_ready=1.
  - Frame register and last-frame register are 0.
- Holding register (1 entry):
  - An accept (valid && ready) sets it full.
  - A frame load empties it.
  - sample_ready = ~full; this is derived from registered state only.
- Divider: div_cnt runs 0..BCLK_DIV-1; at terminal count, i2s_bclk toggles.
  - A 0→1 toggle is a rising edge; a 1→0 toggle is a falling edge.
- Bit counter: bit_cnt runs 0..2*SLOT_BITS-1 and advances on each falling edge, wrapping to 0.
  - i2s_lrclk = (bit_cnt ≥ SLOT_BITS).
- Slot bit b (0 = first BCLK after the LRCLK edge):
  - b=0: sdata=0.
  - b=1..SAMPLE_BITS: sdata = channel bit [SAMPLE_BITS-b], MSB first.
  - b > SAMPLE_BITS: sdata=0.
- Frame load happens on the falling edge where bit_cnt wraps to 0:
  - If the holding register is full: frame register ← holding register, holding register emptied, frame_start pulses.
  - Otherwise: an underrun frame is loaded (see Configuration); frame_start and underrun both pulse.
- Idle (tx_en=0):
  - div_cnt=0, bit_cnt=2*SLOT_BITS-1.
  - bclk, lrclk and sdata are forced 0; no frame loads occur.
  - The holding register still accepts one sample.
- tx_en falling mid-frame: the outputs go to idle on the next clk; the partial frame is discarded; the holding register is kept.
- Width rule: the frame register is 2*SAMPLE_BITS wide; there is no sign extension or truncation.

## Timing
- BCLK period = 2*BCLK_DIV clk cycles; frame = 2*SLOT_BITS BCLK periods.
- All outputs are registered; sdata and lrclk update in the same clk as the bclk 1→0 transition.
- Start-up after tx_en rises:
  - The first rising edge comes BCLK_DIV clks later.
  - The first falling edge, which is also the first frame load, comes 2*BCLK_DIV clks after tx_en rises.
- Accept to transmit: a sample accepted before a load edge goes out in that frame. Its left MSB appears one BCLK after the load edge.
- Sample accepted in the same clk as a load edge with the holding register empty:
  - The load sees the register as empty, so underrun pulses.
  - The sample stays held for the next frame.
- Sample accepted in the same clk as a load edge with the holding register full: impossible, because ready=0.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronously).

## Configuration
- I2S_TX_HOLD_ON_UNDERRUN_EN defined: an underrun frame repeats the last successfully loaded frame; before any sample has loaded, that is 0.
- Macro undefined: an underrun frame is all zeros, i.e. silence.
- In both cases the underrun pulse and frame timing are identical.

## Test plan
All scenarios use defaults (BCLK_DIV=4: BCLK period 8 clk, frame 512 clk).

- Reset, then tx_en=1, with no stimulus → first bclk rise at clk 4 and fall at clk 8; lrclk period 512 clk; sdata=0; underrun pulses every 512 clk.
- Push 0xA5C3_0F0F before enable, then enable → left slot bits 1..16 = 1010_0101_1100_0011 MSB first; right slot bits 1..16 = 0x0F0F; slot bits 0 and 17..31 = 0; one frame_start.
- Stream 4 samples, each offered when sample_ready=1 → 4 consecutive frames with no underrun, and each word is reproduced bit-exact.
- Push 0x8001_7FFE once, then starve the input → frame 2 carries 0x8001_7FFE with the macro defined and 0 without it; underrun pulses at the frame 2 load.
- Offer a sample exactly in the load-edge clk with the holding register empty → underrun pulses in that clk, and the sample is transmitted in the next frame.
- Drop tx_en at bit_cnt=20 and then reassert it; separately, pulse reset_n low mid-frame → outputs are 0 within 1 clk; after re-enable, the first load occurs 8 clk later and the held sample is intact; reset returns sample_ready to 1.
